// File: rtl/dmem_req.sv
// dmem_req: data-side bus initiator from EX to MEM; one SRAM-like transaction per memory op.
// Optional misaligned-access detection is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_req (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ex_memop_i,
    input  logic [31:0] ex_memaddr_i,
    input  logic [31:0] ex_storedata_i,
    input  logic        ex_flush_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] mem_memdata_o,
    output logic [1:0]  mem_memaddr_low_o,
    output logic        dmem_stall_o,
    output logic        dm_adel_o,
    output logic        dm_ades_o
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;

    logic [1:0]  state, state_n;
    logic        kill, kill_eff, is_half, is_word, is_store, misalign, acc, launch, resp;
    logic [1:0]  size_n;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;

    assign is_half  = ex_memop_i[2] | ex_memop_i[3] | ex_memop_i[6];
    assign is_word  = ex_memop_i[4] | ex_memop_i[7];
    assign is_store = |ex_memop_i[7:5];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (is_half & ex_memaddr_i[0]) | (is_word & (ex_memaddr_i[1:0] != 2'b00));

    // one-cycle address-error pulse for a misaligned op seen while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_adel_o <= 1'b0;
            dm_ades_o <= 1'b0;
        end else begin
            dm_adel_o <= (state == IDLE) & ~ex_flush_i & misalign & ~is_store;
            dm_ades_o <= (state == IDLE) & ~ex_flush_i & misalign & is_store;
        end
    end
`else
    assign misalign  = 1'b0;
    assign dm_adel_o = 1'b0;
    assign dm_ades_o = 1'b0;
`endif

    assign acc          = (ex_memop_i != 8'd0) & ~ex_flush_i & ~misalign;
    assign launch       = (state == IDLE) & acc;
    assign kill_eff     = kill | ex_flush_i;
    assign resp         = (((state == REQ) & data_addr_ok) | (state == WAIT)) & data_data_ok;
    assign dmem_stall_o = launch | (state == REQ) | (state == WAIT);

    // request fields derived from the EX-stage op, address and store value
    always_comb begin
        size_n  = is_word ? 2'd2 : is_half ? 2'd1 : 2'd0;
        wstrb_n = ex_memop_i[5] ? (4'b0001 << ex_memaddr_i[1:0]) :
                  ex_memop_i[6] ? (ex_memaddr_i[1] ? 4'b1100 : 4'b0011) :
                  ex_memop_i[7] ? 4'b1111 : 4'b0000;
        wdata_n = ex_memop_i[5] ? {4{ex_storedata_i[7:0]}} :
                  ex_memop_i[6] ? {2{ex_storedata_i[15:0]}} : ex_storedata_i;
    end

    // a killed access returns straight to IDLE so the pipeline never sees a DONE for it
    always_comb begin
        state_n = (state == IDLE) ? (acc ? REQ : IDLE) :
                  (state == REQ)  ? (data_addr_ok ? (data_data_ok ? (kill_eff ? IDLE : DONE) : WAIT) : REQ) :
                  (state == WAIT) ? (data_data_ok ? (kill_eff ? IDLE : DONE) : WAIT) : IDLE;
    end

    // FSM, kill flag and registered bus request; fields are frozen once a request leaves IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            kill       <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wstrb <= 4'd0;
            data_wdata <= 32'd0;
        end else begin
            state    <= state_n;
            kill     <= ((state_n == REQ) | (state_n == WAIT)) & kill_eff;
            data_req <= state_n == REQ;
            if (launch) begin
                data_wr    <= is_store;
                data_size  <= size_n;
                data_addr  <= ex_memaddr_i;
                data_wstrb <= wstrb_n;
                data_wdata <= wdata_n;
            end
        end
    end

    // capture the read word and address low bits on completion of a live access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_memdata_o     <= 32'd0;
            mem_memaddr_low_o <= 2'd0;
        end else if (resp & ~kill_eff) begin
            mem_memdata_o     <= data_rdata;
            mem_memaddr_low_o <= data_addr[1:0];
        end
    end
endmodule

// File: tb/tb_dmem_req.sv
// tb_dmem_req: table-driven bench for dmem_req with a bus responder and completion scoreboard.
module tb_dmem_req;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ex_memop_i = 8'd0;
    logic [31:0] ex_memaddr_i = 32'd0;
    logic [31:0] ex_storedata_i = 32'd0;
    logic        ex_flush_i = 1'b0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic [31:0] mem_memdata_o;
    logic [1:0]  mem_memaddr_low_o;
    logic        dmem_stall_o, dm_adel_o, dm_ades_o;

    dmem_req dut (
        .clk(clk), .rst_n(rst_n),
        .ex_memop_i(ex_memop_i), .ex_memaddr_i(ex_memaddr_i),
        .ex_storedata_i(ex_storedata_i), .ex_flush_i(ex_flush_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_memdata_o(mem_memdata_o), .mem_memaddr_low_o(mem_memaddr_low_o),
        .dmem_stall_o(dmem_stall_o), .dm_adel_o(dm_adel_o), .dm_ades_o(dm_ades_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          a_dly;
        int          d_dly;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic [31:0] mem;
        logic [1:0]  low;
    } exp_t;

    int          pass_n = 0;
    int          total_n = 0;
    exp_t        sb[$];
    logic [31:0] model_mem = 32'd0;
    logic [1:0]  model_low = 2'd0;
    vec_t        tbl[7];

    function automatic vec_t mk(input string name, input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rdata, input int a_dly,
                                input int d_dly, input logic wr, input logic [1:0] size,
                                input logic [3:0] wstrb, input logic [31:0] wdata);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.sd = sd; v.rdata = rdata;
        v.a_dly = a_dly; v.d_dly = d_dly; v.wr = wr; v.size = size; v.wstrb = wstrb; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drives one op on EX and services it as the bus; fl flushes it in its first WAIT cycle.
    task automatic access(input vec_t v, input bit fl);
        int   rc, wc, stalls, reqs, dok_c;
        bit   acc_seen, dok, fin, fld;
        exp_t e;
        rc = 0; wc = 0; stalls = 0; reqs = 0; dok_c = 0;
        acc_seen = 0; dok = 0; fin = 0; fld = 0;
        if (!fl) begin
            model_mem = v.rdata;
            model_low = v.addr[1:0];
        end
        e.mem = model_mem;
        e.low = model_low;
        sb.push_back(e);
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            ex_flush_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
            if (c == 0) begin
                ex_memop_i = v.op; ex_memaddr_i = v.addr; ex_storedata_i = v.sd;
            end
            if (fld) ex_memop_i = 8'd0;
            if (dok && c == dok_c + 1) begin
                if (fl) ex_memop_i = 8'h10;
                #1;
                chk({v.name, "_stall_end"}, 32'(dmem_stall_o), 32'(fl));
                chk({v.name, "_req_end"}, 32'(data_req), 32'd0);
                chk({v.name, "_stall_cycles"}, 32'(stalls), 32'(2 + v.a_dly + v.d_dly));
                chk({v.name, "_req_cycles"}, 32'(reqs), 32'(1 + v.a_dly));
                if (sb.size() == 0) begin
                    total_n++;
                    $display("FAIL %s_scoreboard: got empty queue expected an entry", v.name);
                end else begin
                    e = sb.pop_front();
                    chk({v.name, "_memdata"}, mem_memdata_o, e.mem);
                    chk({v.name, "_addr_low"}, 32'(mem_memaddr_low_o), 32'(e.low));
                end
                fin = 1;
            end else begin
                if (data_req) begin
                    reqs++;
                    chk({v.name, "_wr"}, 32'(data_wr), 32'(v.wr));
                    chk({v.name, "_size"}, 32'(data_size), 32'(v.size));
                    chk({v.name, "_addr"}, data_addr, v.addr);
                    chk({v.name, "_wstrb"}, 32'(data_wstrb), 32'(v.wstrb));
                    chk({v.name, "_wdata"}, data_wdata, v.wdata);
                    if (rc == v.a_dly) begin
                        data_addr_ok = 1'b1;
                        acc_seen = 1;
                        if (v.d_dly == 0) begin
                            data_data_ok = 1'b1; data_rdata = v.rdata; dok = 1; dok_c = c;
                        end
                    end
                    rc++;
                end else if (acc_seen) begin
                    wc++;
                    if (wc == v.d_dly) begin
                        data_data_ok = 1'b1; data_rdata = v.rdata; dok = 1; dok_c = c;
                    end else if (fl && wc == 1) begin
                        ex_flush_i = 1'b1; fld = 1;
                    end
                end
                #1;
                if (c == 0) begin
                    chk({v.name, "_stall_start"}, 32'(dmem_stall_o), 32'd1);
                    chk({v.name, "_req_start"}, 32'(data_req), 32'd0);
                end
                if (dmem_stall_o) stalls++;
            end
        end
        if (!fin) begin
            total_n++;
            $display("FAIL %s_timeout: got no completion within 60 cycles expected one", v.name);
        end
    endtask

    task automatic idle_ex();
        @(negedge clk);
        ex_memop_i = 8'd0; ex_flush_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    endtask

    initial begin
        tbl[0] = mk("sw_100",  8'h80, 32'h100, 32'h12345678, 32'hCAFE0001, 0, 0, 1'b1, 2'd2, 4'b1111, 32'h12345678);
        tbl[1] = mk("sb_203",  8'h20, 32'h203, 32'h000000AB, 32'h11111111, 0, 1, 1'b1, 2'd0, 4'b1000, 32'hABABABAB);
        tbl[2] = mk("lh_402",  8'h04, 32'h402, 32'h0,        32'hBEEF0000, 2, 3, 1'b0, 2'd1, 4'b0000, 32'h0);
        tbl[3] = mk("sh_006",  8'h40, 32'h006, 32'h99995A5A, 32'h22222222, 1, 0, 1'b1, 2'd1, 4'b1100, 32'h5A5A5A5A);
        tbl[4] = mk("lbu_011", 8'h02, 32'h011, 32'h0,        32'h00AB0000, 0, 2, 1'b0, 2'd0, 4'b0000, 32'h0);
        tbl[5] = mk("sb_200",  8'h20, 32'h200, 32'h00000012, 32'h33333333, 0, 0, 1'b1, 2'd0, 4'b0001, 32'h12121212);
        tbl[6] = mk("sh_010",  8'h40, 32'h010, 32'h0000ABCD, 32'h44444444, 0, 0, 1'b1, 2'd1, 4'b0011, 32'hABCDABCD);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wr", 32'(data_wr), 32'd0);
        chk("rst_size", 32'(data_size), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        chk("rst_wdata", data_wdata, 32'd0);
        chk("rst_memdata", mem_memdata_o, 32'd0);
        chk("rst_addr_low", 32'(mem_memaddr_low_o), 32'd0);
        chk("rst_stall", 32'(dmem_stall_o), 32'd0);
        chk("rst_adel", 32'(dm_adel_o), 32'd0);
        chk("rst_ades", 32'(dm_ades_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'h77777777;
        @(negedge clk);
        data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk("idle_stray_data_ok", mem_memdata_o, 32'd0);
        chk("idle_stray_req", 32'(data_req), 32'd0);

        for (int i = 0; i < 7; i++) access(tbl[i], 1'b0);
        idle_ex();

        access(mk("lw_flush", 8'h10, 32'h300, 32'h0, 32'hDEADBEEF, 0, 3, 1'b0, 2'd2, 4'b0000, 32'h0), 1'b1);
        @(negedge clk);
        chk("refill_req", 32'(data_req), 32'd1);
        chk("refill_addr", data_addr, 32'h300);
        ex_memop_i = 8'd0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(data_req), 32'd0);
        chk("midrst_stall", 32'(dmem_stall_o), 32'd0);
        chk("midrst_memdata", mem_memdata_o, 32'd0);
        model_mem = 32'd0; model_low = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("postrst_req", 32'(data_req), 32'd0);

        access(mk("b2b_lw", 8'h10, 32'h040, 32'h0, 32'h0BADF00D, 1, 1, 1'b0, 2'd2, 4'b0000, 32'h0), 1'b0);
        access(mk("b2b_sw", 8'h80, 32'h044, 32'hFEEDFACE, 32'h5555AAAA, 0, 2, 1'b1, 2'd2, 4'b1111, 32'hFEEDFACE), 1'b0);
        idle_ex();

`ifdef DMEM_ALIGN_CHECK_EN
        @(negedge clk);
        ex_memop_i = 8'h10; ex_memaddr_i = 32'h101;
        #1;
        chk("unal_lw_stall", 32'(dmem_stall_o), 32'd0);
        @(negedge clk);
        ex_memop_i = 8'd0;
        #1;
        chk("unal_lw_adel", 32'(dm_adel_o), 32'd1);
        chk("unal_lw_ades", 32'(dm_ades_o), 32'd0);
        chk("unal_lw_req", 32'(data_req), 32'd0);
        @(negedge clk);
        ex_memop_i = 8'h80; ex_memaddr_i = 32'h102;
        #1;
        chk("unal_adel_pulse_end", 32'(dm_adel_o), 32'd0);
        @(negedge clk);
        ex_memop_i = 8'd0;
        #1;
        chk("unal_sw_ades", 32'(dm_ades_o), 32'd1);
        chk("unal_sw_req", 32'(data_req), 32'd0);
        @(negedge clk);
        #1;
        chk("unal_ades_pulse_end", 32'(dm_ades_o), 32'd0);
`else
        access(mk("lw_101", 8'h10, 32'h101, 32'h0, 32'h55AA55AA, 0, 0, 1'b0, 2'd2, 4'b0000, 32'h0), 1'b0);
        chk("lw_101_adel", 32'(dm_adel_o), 32'd0);
        idle_ex();
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/dmem_req.md
# dmem_req

Data-side bus initiator between the EX and MEM stages. Turns the EX stage's memory op, address and store data into one SRAM-like data-bus transaction (req/addr_ok/data_ok), with store byte enables and replicated write data. Stalls the pipeline until the transaction completes, then holds the raw read word and address low bits for the MEM stage's load extraction.

## Interface
Parameters:
- none; the memop encoding is fixed: 8-bit one-hot, [0]lb [1]lbu [2]lh [3]lhu [4]lw [5]sb [6]sh [7]sw; all-zero = no access.

Ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_memop_i  in  8  one-hot op of the EX-stage instruction.
- ex_memaddr_i  in  32  effective address.
- ex_storedata_i  in  32  rt value for stores; low byte/half used for sb/sh.
- ex_flush_i  in  1  pipeline flush; kills the current/outstanding access.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  byte address.
- data_wstrb  out  4  byte enables; 0 for loads.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response; rdata valid.
- data_rdata  in  32  read word.
- mem_memdata_o  out  32  captured read word.
- mem_memaddr_low_o  out  2  address[1:0] of the completed access.
- dmem_stall_o  out  1  holds the IF..EX stages.
- dm_adel_o, dm_ades_o  out  1 each  misaligned load/store (DMEM_ALIGN_CHECK_EN only; else tied 0).

## Operation
- acc = (ex_memop_i != 0) & ~ex_flush_i & ~misalign. misalign is always 0 without the macro.
- Request fields are computed from the EX inputs and registered when leaving IDLE:
  - sb: wstrb = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - sh: wstrb = addr[1] ? 1100 : 0011; wdata = {2{half}}.
  - sw: wstrb = 1111; wdata = value unchanged.
  - loads: wstrb = 0; size follows the op width.
- FSM:
  - IDLE: if acc, latch the request fields → REQ.
  - REQ: data_req = 1, all fields held stable. On addr_ok: to DONE if data_ok is also high this cycle, else → WAIT.
  - WAIT: on data_ok → DONE.
  - DONE: single cycle → IDLE.
- When data_ok arrives on a live access, data_rdata and addr[1:0] are captured into mem_memdata_o and mem_memaddr_low_o. Both hold until the next completion.
- dmem_stall_o = (IDLE & acc) | REQ | WAIT. It is 0 in DONE, so the pipeline advances exactly once per access. IDLE with no access also gives 0.
- Flush:
  - In IDLE: no request is issued.
  - In REQ: the request is still held until addr_ok (no withdrawal); the kill flag is set.
  - In WAIT: the kill flag is set.
  - A killed transaction: data_ok leads to IDLE (not DONE), outputs are not updated, and stall stays asserted until data_ok.
- Exactly one outstanding transaction; a new request is never issued before data_ok of the previous one.

## Timing
- Reset values:
  - data_req 0, data_wr 0, data_size 0, data_addr 0, data_wstrb 0, data_wdata 0.
  - mem_memdata_o 0, mem_memaddr_low_o 0, kill 0, dm_adel_o/dm_ades_o 0.
  - State IDLE.
- dmem_stall_o is combinational from the state and EX inputs. All bus outputs come from registers.
- Minimum access: 3 cycles (IDLE-detect, REQ with addr_ok & data_ok, DONE). Each cycle of addr_ok or data_ok delay adds one cycle.
- Reset mid-transaction returns to IDLE immediately. An in-flight response is the bus's responsibility; it is ignored in IDLE.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - misalign = (half & addr[0]) | (word & addr[1:0] != 0).
  - A misaligned access issues no request and does not stall.
  - dm_adel_o/dm_ades_o are registered high for one cycle, then the pipeline proceeds.
- Undefined: no check; the address passes through as given and the flags are tied 0.

## Test plan
- sw 0x12345678 @0x100, addr_ok+data_ok in REQ → wstrb 1111, size 2, data_req for 1 cycle, stall 2 cycles.
- sb 0xAB @0x203 → wstrb 1000, wdata 0xABABABAB, size 0.
- lh @0x402, addr_ok delay 2, data_ok delay 3, rdata 0xBEEF0000 → mem_memdata_o 0xBEEF0000, mem_memaddr_low_o 2, stall low only in DONE.
- lw issued, flush during WAIT, data_ok rdata 0xDEADBEEF → mem_memdata_o unchanged, stall until data_ok, no DONE cycle.
- Back-to-back lw/sw → second data_req rises only after the first data_ok; one DONE per access.
- DMEM_ALIGN_CHECK_EN: lw @0x101 → no data_req, dm_adel_o pulses once; without the macro, a request with addr 0x101 is issued.
